// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: header geometry, broadcast address and the
// receive header parser state encoding.
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int MAC_ADDR_WIDTH = 48;
  localparam logic [MAC_ADDR_WIDTH-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    HEADER,
    HDR_WAIT,
    PAYLOAD,
    DROP
  } hdr_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_hdr_parser.sv
// Splits a received Ethernet frame into a registered header (dest, src, type)
// and a combinational payload passthrough, dropping runts and foreign frames.
module eth_rx_hdr_parser
  import eth_pkg::*;
#(
  parameter logic [MAC_ADDR_WIDTH-1:0] STATION_MAC = 48'h00_0A_35_00_01_02,
  parameter bit PROMISCUOUS = 1'b0
) (
  input  logic                      clk_100,
  input  logic                      reset_n,
  input  logic [7:0]                s_rx_axis_tdata,
  input  logic                      s_rx_axis_tvalid,
  input  logic                      s_rx_axis_tuser,
  input  logic                      s_rx_axis_tlast,
  output logic                      s_rx_axis_trdy,
  output logic                      m_hdr_valid,
  input  logic                      m_hdr_rdy,
  output logic [MAC_ADDR_WIDTH-1:0] m_hdr_dest_mac,
  output logic [MAC_ADDR_WIDTH-1:0] m_hdr_src_mac,
  output logic [15:0]               m_hdr_eth_type,
  output logic [7:0]                m_pld_axis_tdata,
  output logic                      m_pld_axis_tvalid,
  output logic                      m_pld_axis_tuser,
  output logic                      m_pld_axis_tlast,
  input  logic                      m_pld_axis_trdy,
  output logic [15:0]               drop_cnt
);

  localparam logic [3:0] LAST_HDR_IDX = 4'(ETH_HDR_BYTES - 1);

  hdr_state_e state;
  logic [3:0] byte_cnt;
  logic       rx_fire;
  logic       dest_ok;

  // Handshake: a byte moves on a rising edge where tvalid && trdy on that
  // side. Input ready is held low while reset is asserted.
  assign s_rx_axis_trdy = reset_n &&
                          ((state == HEADER) || (state == DROP) ||
                           ((state == PAYLOAD) && m_pld_axis_trdy));
  assign rx_fire = s_rx_axis_tvalid && s_rx_axis_trdy;

  // The destination register is complete once byte 5 is in, so it is
  // already final when byte 13 is accepted.
  assign dest_ok = PROMISCUOUS ||
                   (m_hdr_dest_mac == STATION_MAC) ||
                   (m_hdr_dest_mac == BCAST_MAC);

  assign m_pld_axis_tdata  = s_rx_axis_tdata;
  assign m_pld_axis_tuser  = s_rx_axis_tuser;
  assign m_pld_axis_tlast  = s_rx_axis_tlast;
  assign m_pld_axis_tvalid = reset_n && (state == PAYLOAD) && s_rx_axis_tvalid;

  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      state          <= HEADER;
      byte_cnt       <= 4'd0;
      m_hdr_valid    <= 1'b0;
      m_hdr_dest_mac <= '0;
      m_hdr_src_mac  <= '0;
      m_hdr_eth_type <= '0;
      drop_cnt       <= '0;
    end else begin
      case (state)
        HEADER: begin
          if (rx_fire) begin
            if (byte_cnt < 4'd6)
              m_hdr_dest_mac <= {m_hdr_dest_mac[39:0], s_rx_axis_tdata};
            else if (byte_cnt < 4'd12)
              m_hdr_src_mac <= {m_hdr_src_mac[39:0], s_rx_axis_tdata};
            else
              m_hdr_eth_type <= {m_hdr_eth_type[7:0], s_rx_axis_tdata};

            if (s_rx_axis_tlast) begin
              byte_cnt <= 4'd0;
              drop_cnt <= sat_inc16(drop_cnt);
            end else if (byte_cnt == LAST_HDR_IDX) begin
              byte_cnt <= 4'd0;
              if (dest_ok) begin
                state       <= HDR_WAIT;
                m_hdr_valid <= 1'b1;
              end else begin
                state <= DROP;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        HDR_WAIT: begin
          if (m_hdr_rdy) begin
            state       <= PAYLOAD;
            m_hdr_valid <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (rx_fire && s_rx_axis_tlast) state <= HEADER;
        end
        DROP: begin
          if (rx_fire && s_rx_axis_tlast) begin
            drop_cnt <= sat_inc16(drop_cnt);
            state    <= HEADER;
          end
        end
        default: state <= HEADER;
      endcase
    end
  end

endmodule

// File: doc/eth_rx_hdr_parser.md
ETH_RX_HDR_PARSER -- requirements
Module: eth_rx_hdr_parser

Interface
REQ-001 SHALL have parameter STATION_MAC, default 48'h00_0A_35_00_01_02, local MAC address for destination filtering.
REQ-002 SHALL have parameter PROMISCUOUS, default 0, meaning 1 accepts every destination address.
REQ-003 SHALL have port clk_100  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port s_rx_axis_tdata  input  8  frame byte from RX FIFO.
REQ-006 SHALL have port s_rx_axis_tvalid  input  1  byte valid.
REQ-007 SHALL have port s_rx_axis_tuser  input  1  frame-error flag, meaningful with tlast.
REQ-008 SHALL have port s_rx_axis_tlast  input  1  last byte of frame.
REQ-009 SHALL have port s_rx_axis_trdy  output  1  parser accepts byte.
REQ-010 SHALL have port m_hdr_valid  output  1  header fields valid.
REQ-011 SHALL have port m_hdr_rdy  input  1  header consumer ready.
REQ-012 SHALL have port m_hdr_dest_mac / m_hdr_src_mac  output  48 each  parsed addresses, byte 0 in bits [47:40].
REQ-013 SHALL have port m_hdr_eth_type  output  16  EtherType, byte 12 in [15:8].
REQ-014 SHALL have ports m_pld_axis_tdata (8), m_pld_axis_tvalid, m_pld_axis_tuser, m_pld_axis_tlast  output  payload stream.
REQ-015 SHALL have port m_pld_axis_trdy  input  1  payload consumer ready.
REQ-016 SHALL have port drop_cnt  output  16  saturating count of discarded frames.

Function
REQ-017 A byte SHALL transfer on any edge with tvalid && trdy on the same side.
REQ-018 FSM states SHALL be HEADER, HDR_WAIT, PAYLOAD, DROP; reset state HEADER.
REQ-019 HEADER: s_rx_axis_trdy=1; 4-bit byte counter 0..13 captures each accepted byte into header shift registers.
REQ-020 On accepting byte 13 without tlast: if dest equals STATION_MAC, equals 48'hFFFF_FFFF_FFFF, or PROMISCUOUS=1 -> HDR_WAIT with m_hdr_valid=1 the next cycle; else -> DROP.
REQ-021 tlast accepted at header byte 0..13 (runt, including exactly 14 bytes) SHALL discard the frame, increment drop_cnt, return to HEADER, no header output.
REQ-022 HDR_WAIT: s_rx_axis_trdy=0; header fields stable; on m_hdr_valid && m_hdr_rdy -> PAYLOAD, m_hdr_valid=0 next cycle.
REQ-023 PAYLOAD: zero-latency passthrough; m_pld_axis_tdata/tvalid/tlast/tuser = s_rx_axis_* ; s_rx_axis_trdy = m_pld_axis_trdy; tvalid gated to 0 outside PAYLOAD.
REQ-024 PAYLOAD: on accepted tlast -> HEADER, counter cleared; tuser forwarded unchanged (error frames are not counted as drops).
REQ-025 DROP: s_rx_axis_trdy=1, nothing forwarded; on accepted tlast increment drop_cnt, -> HEADER.
REQ-026 drop_cnt SHALL saturate at 16'hFFFF.
REQ-027 Stalls (tvalid=0) SHALL not advance counter or state in any state.
REQ-028 Header fields SHALL remain unchanged from entry to HDR_WAIT until the next frame's byte 0 is accepted.

Reset
REQ-029 On clk_100 edge with reset_n=0: state HEADER, counter 0, m_hdr_valid=0, m_pld_axis_tvalid=0, header fields 0, drop_cnt 0, s_rx_axis_trdy=0 during reset.
REQ-030 Reset mid-frame SHALL abort the frame without output; first byte accepted after release is header byte 0 (RX FIFO shares reset).

Structure
REQ-031 Shared package eth_pkg SHALL hold ETH_HDR_BYTES=14, MAC_ADDR_WIDTH=48, BCAST_MAC, and the FSM state enum.
REQ-032 Single module, no sub-modules; payload path purely combinational, header path registered.

Verification
REQ-033 Frame dest=STATION_MAC, src=48'h11_22_33_44_55_66, type 16'h0800, 46 payload bytes 0x00..0x2D -> one header with those fields, 46 payload bytes in order, tlast on 0x2D, tuser=0.
REQ-034 Same frame, dest=48'h02_00_00_00_00_99, PROMISCUOUS=0 -> no header, no payload, drop_cnt=1; with PROMISCUOUS=1 -> forwarded.
REQ-035 Broadcast frame with tuser=1 on last of 60 payload bytes -> forwarded, m_pld_axis_tuser=1 on tlast, drop_cnt=0.
REQ-036 10-byte runt and exactly-14-byte frame back-to-back, then valid frame -> drop_cnt=2, valid frame parsed correctly.
REQ-037 m_hdr_rdy held 0 for 20 cycles, then random 50% m_pld_axis_trdy -> s_rx_axis_trdy=0 during wait, payload bytes lossless and ordered.
REQ-038 reset_n pulsed low at payload byte 10 -> all outputs reset values next edge; following frame parsed correctly.
